// File: rtl/onehot_decoder_seq.sv
// rtl/onehot_decoder_seq.sv - queued 3-to-8 one-hot decoder with programmable hold; ONEHOT_DEC_GAP_EN adds a break-before-make gap cycle
module onehot_decoder_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [2:0]               in_code,
    output logic                     in_ready,
    output logic [7:0]               y,
    output logic                     y_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL  = (AW + 1)'(DEPTH);
    localparam logic [7:0]  HOLD_RELOAD = 8'(HOLD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
`ifdef ONEHOT_DEC_GAP_EN
    localparam logic [1:0] S_GAP   = 2'd2;
`endif

    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [7:0]    hold_cnt;
    logic          push;
    logic          pop;
    logic          fifo_nempty;
    logic [7:0]    head_onehot;

    assign fifo_nempty = (count != '0);
    assign in_ready    = (count != FULL_LEVEL);
    assign push        = in_valid && in_ready;
    assign head_onehot = 8'h01 << mem[rd_ptr];
    assign level       = count;
    assign y_valid     = (state == S_DRIVE);
    assign busy        = (state != S_IDLE) || fifo_nempty;

    // A pop always coincides with loading the head code into y.
    always_comb begin
        pop = 1'b0;
        case (state)
            S_IDLE:  pop = fifo_nempty;
`ifdef ONEHOT_DEC_GAP_EN
            S_DRIVE: pop = 1'b0;
            S_GAP:   pop = fifo_nempty;
`else
            S_DRIVE: pop = (hold_cnt == 8'd0) && fifo_nempty;
`endif
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            y        <= 8'h00;
            hold_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        y        <= head_onehot;
                        hold_cnt <= HOLD_RELOAD;
                        state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (hold_cnt != 8'd0) begin
                        hold_cnt <= hold_cnt - 8'd1;
                    end else if (fifo_nempty) begin
`ifdef ONEHOT_DEC_GAP_EN
                        y     <= 8'h00;
                        state <= S_GAP;
`else
                        y        <= head_onehot;
                        hold_cnt <= HOLD_RELOAD;
`endif
                    end else begin
                        y     <= 8'h00;
                        state <= S_IDLE;
                    end
                end
`ifdef ONEHOT_DEC_GAP_EN
                S_GAP: begin
                    if (pop) begin
                        y        <= head_onehot;
                        hold_cnt <= HOLD_RELOAD;
                        state    <= S_DRIVE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    y     <= 8'h00;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
